// File: rtl/program_loader.sv
// Serial byte-stream loader for instruction memory: pairs bytes (high first) into
// 16-bit words and writes them at consecutive addresses until the host ends or memory fills.
module program_loader #(
  parameter int MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  input  logic        end_load,
  output logic        we,
  output logic [15:0] instruction,
  output logic [7:0]  instruct_dir,
  output logic        finish,
  output logic [8:0]  word_count,
  output logic        error
);

  localparam logic [8:0] MAXW = 9'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_HI, S_LOAD_LO, S_WRITE, S_DONE
  } state_t;

  state_t      r_state, w_next;
  logic [7:0]  r_hi;
  logic [15:0] r_instr;
  logic [7:0]  r_dir;
  logic [8:0]  r_count;
  logic        r_error;
  logic        r_full_chk;
  logic        w_start_ok;
  logic        w_full;

  assign w_start_ok = start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_full     = (r_count + 9'd1) == MAXW;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // end_load takes priority over a byte arriving in the same cycle
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start) w_next = S_LOAD_HI;
      S_LOAD_HI: if (end_load) w_next = S_DONE;
                 else if (byte_valid) w_next = S_LOAD_LO;
      S_LOAD_LO: if (end_load) w_next = S_DONE;
                 else if (byte_valid) w_next = S_WRITE;
      S_WRITE:   w_next = w_full ? S_DONE : S_LOAD_HI;
      S_DONE:    if (start) w_next = S_LOAD_HI;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    byte_ready = 1'b0;
    we         = 1'b0;
    finish     = 1'b0;
    case (r_state)
      S_LOAD_HI, S_LOAD_LO: byte_ready = 1'b1;
      S_WRITE:              we         = 1'b1;
      S_DONE:               finish     = 1'b1;
      default:              ;
    endcase
  end

  // The output word only updates on the low-byte transfer, so a dropped
  // partial word never reaches instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hi       <= '0;
      r_instr    <= '0;
      r_dir      <= '0;
      r_count    <= '0;
      r_error    <= 1'b0;
      r_full_chk <= 1'b0;
    end else begin
      r_full_chk <= 1'b0;
      case (r_state)
        S_LOAD_HI: if (!end_load && byte_valid) r_hi <= byte_in;
        S_LOAD_LO: begin
          if (end_load)        r_error <= 1'b1;
          else if (byte_valid) r_instr <= {r_hi, byte_in};
        end
        S_WRITE: begin
          r_dir      <= r_dir + 8'd1;
          r_count    <= r_count + 9'd1;
          r_full_chk <= w_full;
        end
        // host still pushing bytes right after memory filled
        S_DONE: if (r_full_chk && byte_valid) r_error <= 1'b1;
        default: ;
      endcase
      if (w_start_ok) begin
        r_dir   <= '0;
        r_count <= '0;
        r_error <= 1'b0;
      end
    end
  end

  assign instruction  = r_instr;
  assign instruct_dir = r_dir;
  assign word_count   = r_count;
  assign error        = r_error;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: a default-size instance plus a MAX_WORDS=4
// instance share inputs so overflow and normal sessions can be checked side by side.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset, start, byte_valid, end_load;
  logic [7:0]  byte_in;

  logic        byte_ready, we, finish, error;
  logic [15:0] instruction;
  logic [7:0]  instruct_dir;
  logic [8:0]  word_count;

  logic        byte_ready_4, we_4, finish_4, error_4;
  logic [15:0] instruction_4;
  logic [7:0]  instruct_dir_4;
  logic [8:0]  word_count_4;

  int n_cmp = 0;
  int n_fail = 0;
  logic [23:0] wq[$];
  logic [23:0] wq4[$];

  always #5 clk = ~clk;

  program_loader u_main (
    .clk(clk), .reset(reset), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .end_load(end_load),
    .we(we), .instruction(instruction), .instruct_dir(instruct_dir),
    .finish(finish), .word_count(word_count), .error(error)
  );

  program_loader #(.MAX_WORDS(4)) u_small (
    .clk(clk), .reset(reset), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready_4), .end_load(end_load),
    .we(we_4), .instruction(instruction_4), .instruct_dir(instruct_dir_4),
    .finish(finish_4), .word_count(word_count_4), .error(error_4)
  );

  // write log: {address, word} for every we pulse
  always @(negedge clk) begin
    if (we)   wq.push_back({instruct_dir, instruction});
    if (we_4) wq4.push_back({instruct_dir_4, instruction_4});
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1; tick(); reset = 1'b0; tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit use4, input int gap);
    bit sent = 0;
    bit rdy;
    byte_valid = 1'b0;
    repeat (gap) tick();
    byte_in = b; byte_valid = 1'b1;
    for (int k = 0; k < 20 && !sent; k++) begin
      rdy = use4 ? byte_ready_4 : byte_ready;
      tick();
      if (rdy) sent = 1;
    end
    byte_valid = 1'b0;
    if (!sent) begin
      n_cmp++; n_fail++;
      $display("FAIL send_timeout: byte %02h not accepted, want accepted within 20 cycles", b);
    end
  endtask

  task automatic do_end();
    bit ok = 0;
    for (int k = 0; k < 10 && !ok; k++) begin
      if (byte_ready) ok = 1;
      else tick();
    end
    if (ok) begin
      end_load = 1'b1; tick(); end_load = 1'b0;
    end else begin
      n_cmp++; n_fail++;
      $display("FAIL end_timeout: byte_ready never 1, want 1 within 10 cycles");
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    n_cmp++; if ({we, byte_ready, finish, error} !== 4'b0000) begin n_fail++;
      $display("FAIL rst_ctrl: got %b want 0000", {we, byte_ready, finish, error}); end
    n_cmp++; if (word_count !== 9'd0) begin n_fail++;
      $display("FAIL rst_count: got %0d want 0", word_count); end
    n_cmp++; if (instruct_dir !== 8'h00) begin n_fail++;
      $display("FAIL rst_dir: got %02h want 00", instruct_dir); end
    n_cmp++; if (instruction !== 16'h0000) begin n_fail++;
      $display("FAIL rst_instr: got %04h want 0000", instruction); end
    n_cmp++; if ({we_4, byte_ready_4, finish_4, error_4} !== 4'b0000) begin n_fail++;
      $display("FAIL rst_small: got %b want 0000", {we_4, byte_ready_4, finish_4, error_4}); end
    reset = 1'b0;
    tick();
    n_cmp++; if ({byte_ready, finish} !== 2'b00) begin n_fail++;
      $display("FAIL idle_quiet: got %b want 00", {byte_ready, finish}); end
  endtask

  task automatic test_two_words();
    wq.delete();
    pulse_start();
    n_cmp++; if ({byte_ready, finish} !== 2'b10) begin n_fail++;
      $display("FAIL 2w_loadhi: ready,finish got %b want 10", {byte_ready, finish}); end
    send_byte(8'h12, 0, 0);
    send_byte(8'h34, 0, 0);
    n_cmp++; if ({we, instruct_dir, instruction} !== {1'b1, 8'h00, 16'h1234}) begin n_fail++;
      $display("FAIL 2w_latency: we,dir,instr got %b,%02h,%04h want 1,00,1234", we, instruct_dir, instruction); end
    send_byte(8'hAB, 0, 0);
    send_byte(8'hCD, 0, 0);
    do_end();
    n_cmp++; if ({finish, error, we} !== 3'b100) begin n_fail++;
      $display("FAIL 2w_flags: finish,error,we got %b want 100", {finish, error, we}); end
    n_cmp++; if (word_count !== 9'd2) begin n_fail++;
      $display("FAIL 2w_count: got %0d want 2", word_count); end
    n_cmp++; if (instruct_dir !== 8'h02) begin n_fail++;
      $display("FAIL 2w_dir: got %02h want 02", instruct_dir); end
    n_cmp++;
    if (wq.size() != 2) begin n_fail++;
      $display("FAIL 2w_writes: got %0d writes want 2", wq.size()); end
    else if (wq[0] !== 24'h001234 || wq[1] !== 24'h01ABCD) begin n_fail++;
      $display("FAIL 2w_writes: got %06h %06h want 001234 01ABCD", wq[0], wq[1]); end
  endtask

  task automatic test_partial();
    wq.delete();
    pulse_start();
    send_byte(8'h12, 0, 0);
    do_end();
    n_cmp++; if ({finish, error} !== 2'b11) begin n_fail++;
      $display("FAIL part_flags: finish,error got %b want 11", {finish, error}); end
    n_cmp++; if (word_count !== 9'd0) begin n_fail++;
      $display("FAIL part_count: got %0d want 0", word_count); end
    n_cmp++; if (wq.size() != 0) begin n_fail++;
      $display("FAIL part_nowrite: got %0d writes want 0", wq.size()); end
    n_cmp++; if (instruction !== 16'hABCD) begin n_fail++;
      $display("FAIL part_hold: instr got %04h want ABCD", instruction); end
  endtask

  task automatic test_end_wins();
    wq.delete();
    pulse_start();
    n_cmp++; if ({error, finish} !== 2'b00) begin n_fail++;
      $display("FAIL ew_clear: error,finish got %b want 00", {error, finish}); end
    byte_in = 8'h77; byte_valid = 1'b1; end_load = 1'b1;
    tick();
    byte_valid = 1'b0; end_load = 1'b0;
    n_cmp++; if ({finish, error, word_count} !== {2'b10, 9'd0}) begin n_fail++;
      $display("FAIL ew_done: finish,error,count got %b,%b,%0d want 1,0,0", finish, error, word_count); end
    tick();
    n_cmp++; if (wq.size() != 0) begin n_fail++;
      $display("FAIL ew_nowrite: got %0d writes want 0", wq.size()); end
  endtask

  task automatic test_start_ignored();
    wq.delete();
    pulse_start();
    send_byte(8'h11, 0, 0);
    pulse_start();
    send_byte(8'h22, 0, 0);
    do_end();
    n_cmp++; if ({finish, error, word_count} !== {2'b10, 9'd1}) begin n_fail++;
      $display("FAIL si_flags: finish,error,count got %b,%b,%0d want 1,0,1", finish, error, word_count); end
    n_cmp++;
    if (wq.size() != 1) begin n_fail++;
      $display("FAIL si_write: got %0d writes want 1", wq.size()); end
    else if (wq[0] !== 24'h001122) begin n_fail++;
      $display("FAIL si_write: got %06h want 001122", wq[0]); end
  endtask

  task automatic test_random_valid();
    logic [15:0] words [3] = '{16'hC0DE, 16'hBEEF, 16'h0F0F};
    int bad = 0;
    wq.delete();
    pulse_start();
    foreach (words[i]) begin
      send_byte(words[i][15:8], 0, int'($urandom_range(0, 3)));
      send_byte(words[i][7:0],  0, int'($urandom_range(0, 3)));
    end
    do_end();
    n_cmp++; if ({finish, error, word_count} !== {2'b10, 9'd3}) begin n_fail++;
      $display("FAIL rv_flags: finish,error,count got %b,%b,%0d want 1,0,3", finish, error, word_count); end
    if (wq.size() == 3)
      foreach (words[i]) if (wq[i] !== {8'(i), words[i]}) bad++;
    n_cmp++; if (wq.size() != 3 || bad != 0) begin n_fail++;
      $display("FAIL rv_stream: got %0d writes, %0d wrong, want 3 writes in order", wq.size(), bad); end
  endtask

  task automatic test_overflow();
    logic [15:0] words [4] = '{16'h1001, 16'h2002, 16'h3003, 16'h4004};
    int bad = 0;
    wq4.delete();
    pulse_start();
    foreach (words[i]) begin
      send_byte(words[i][15:8], 1, 0);
      send_byte(words[i][7:0],  1, 0);
    end
    byte_in = 8'h55; byte_valid = 1'b1;
    tick();
    n_cmp++; if ({finish_4, byte_ready_4} !== 2'b10) begin n_fail++;
      $display("FAIL ov_done: finish,ready got %b want 10", {finish_4, byte_ready_4}); end
    tick();
    n_cmp++; if ({finish_4, error_4, byte_ready_4} !== 3'b110) begin n_fail++;
      $display("FAIL ov_error: finish,error,ready got %b want 110", {finish_4, error_4, byte_ready_4}); end
    n_cmp++; if (word_count_4 !== 9'd4 || instruct_dir_4 !== 8'h04) begin n_fail++;
      $display("FAIL ov_count: count,dir got %0d,%02h want 4,04", word_count_4, instruct_dir_4); end
    repeat (3) tick();
    byte_valid = 1'b0;
    if (wq4.size() == 4)
      foreach (words[i]) if (wq4[i] !== {8'(i), words[i]}) bad++;
    n_cmp++; if (wq4.size() != 4 || bad != 0) begin n_fail++;
      $display("FAIL ov_writes: got %0d writes, %0d wrong, want 4 at dir 0..3", wq4.size(), bad); end
  endtask

  task automatic test_reset_in_write();
    pulse_reset();
    wq.delete();
    pulse_start();
    for (int i = 1; i <= 3; i++) begin
      send_byte(8'h00, 0, 0);
      send_byte(8'(i), 0, 0);
    end
    send_byte(8'h5A, 0, 0);
    send_byte(8'h5A, 0, 0);
    n_cmp++; if ({we, instruct_dir, instruction} !== {1'b1, 8'h03, 16'h5A5A}) begin n_fail++;
      $display("FAIL rw_inwrite: we,dir,instr got %b,%02h,%04h want 1,03,5A5A", we, instruct_dir, instruction); end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if ({we, byte_ready, finish, error} !== 4'b0000) begin n_fail++;
      $display("FAIL rw_async: we,ready,finish,error got %b want 0000", {we, byte_ready, finish, error}); end
    n_cmp++; if ({word_count, instruct_dir, instruction} !== 33'd0) begin n_fail++;
      $display("FAIL rw_regs: count,dir,instr got %0d,%02h,%04h want 0,00,0000", word_count, instruct_dir, instruction); end
    tick();
    reset = 1'b0;
    repeat (4) tick();
    n_cmp++; if (wq.size() != 3 || we !== 1'b0) begin n_fail++;
      $display("FAIL rw_nopulse: writes %0d we %b want 3 writes, we 0", wq.size(), we); end
    wq.delete();
    pulse_start();
    send_byte(8'h01, 0, 0);
    send_byte(8'h02, 0, 0);
    do_end();
    n_cmp++;
    if (wq.size() != 1) begin n_fail++;
      $display("FAIL rw_restart: got %0d writes want 1", wq.size()); end
    else if (wq[0] !== 24'h000102) begin n_fail++;
      $display("FAIL rw_restart: got %06h want 000102", wq[0]); end
  endtask

  task automatic test_full_256();
    int bad = 0;
    pulse_reset();
    wq.delete();
    pulse_start();
    for (int i = 0; i < 256; i++) begin
      send_byte(8'(i), 0, 0);
      send_byte(~8'(i), 0, 0);
    end
    n_cmp++; if ({we, instruct_dir, instruction} !== {1'b1, 8'hFF, 16'hFF00}) begin n_fail++;
      $display("FAIL full_last: we,dir,instr got %b,%02h,%04h want 1,FF,FF00", we, instruct_dir, instruction); end
    tick();
    n_cmp++; if ({finish, error, byte_ready} !== 3'b100) begin n_fail++;
      $display("FAIL full_flags: finish,error,ready got %b want 100", {finish, error, byte_ready}); end
    n_cmp++; if (word_count !== 9'd256 || instruct_dir !== 8'h00) begin n_fail++;
      $display("FAIL full_count: count,dir got %0d,%02h want 256,00", word_count, instruct_dir); end
    if (wq.size() == 256)
      for (int i = 0; i < 256; i++) if (wq[i] !== {8'(i), 8'(i), ~8'(i)}) bad++;
    n_cmp++; if (wq.size() != 256 || bad != 0) begin n_fail++;
      $display("FAIL full_writes: got %0d writes, %0d wrong, want 256 correct", wq.size(), bad); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; byte_valid = 1'b0; end_load = 1'b0; byte_in = 8'h00;
    test_reset();
    test_two_words();
    test_partial();
    test_end_wins();
    test_start_ignored();
    test_random_valid();
    test_overflow();
    test_reset_in_write();
    test_full_256();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
